// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB manager arbiter.
//   arb_state_t    : arbiter FSM encoding (IDLE / OWNED / LOCKED)
//   ARB_MODE_*     : selection mode constants for the MODE parameter
//   onehot_to_idx  : binary encoder for a one-hot (or zero) vector of up to 16 bits
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam int ARB_MODE_RR    = 0;
  localparam int ARB_MODE_FIXED = 1;

  localparam int ARB_MAX_MGR = 16;

  // OR-ing the indices of set bits is an exact encoder for one-hot input
  // and returns 0 for an all-zero vector, which is the idle index.
  function automatic logic [3:0] onehot_to_idx(input logic [ARB_MAX_MGR-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_MGR; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selector.
//   req_vec    : candidate request vector
//   ptr        : index of the most recent winner (round-robin search starts at ptr+1)
//   mode       : 0 = round-robin from ptr+1 with wrap, 1 = lowest set bit
//   win_onehot : one-hot winner, zero if no candidate
//   win_idx    : binary winner index, zero if no candidate
//   win_any    : a candidate exists
module arb_pick
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MGR = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_MGR-1:0] req_vec,
  input  logic [IDXW-1:0]    ptr,
  input  logic               mode,
  output logic [NUM_MGR-1:0] win_onehot,
  output logic [IDXW-1:0]    win_idx,
  output logic               win_any
);

  always_comb begin
    int cand;
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    cand       = 0;
    for (int i = 0; i < NUM_MGR; i++) begin
      // Visit candidates in priority order; the first requester found wins.
      if (mode == 1'(ARB_MODE_FIXED)) cand = i;
      else                            cand = (int'(ptr) + 1 + i) % NUM_MGR;
      if (!win_any && req_vec[cand[IDXW-1:0]]) begin
        win_any                       = 1'b1;
        win_idx                       = cand[IDXW-1:0];
        win_onehot[cand[IDXW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB multi-manager arbiter with round-robin or fixed priority, locked
// transfer support and an optional hold limit. All state advances only on
// HREADY-high cycles so ownership changes on address-phase boundaries.
//   clk          : HCLK
//   reset        : asynchronous, active-high
//   req          : per-manager bus request
//   lock         : per-manager HMASTLOCK
//   HREADY       : bus ready; arbitration evaluated only when high
//   grant        : registered one-hot grant, zero when idle
//   grant_idx    : binary index of grant, zero when idle
//   grant_valid  : grant is non-zero
//   grant_locked : arbiter is in the LOCKED state
// Legal NUM_MGR range is 1..16.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MGR  = 4,
  parameter int IDXW     = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1,
  parameter int MODE     = ARB_MODE_RR,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_MGR-1:0] req,
  input  logic [NUM_MGR-1:0] lock,
  input  logic               HREADY,
  output logic [NUM_MGR-1:0] grant,
  output logic [IDXW-1:0]    grant_idx,
  output logic               grant_valid,
  output logic               grant_locked
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDXW-1:0] PTR_RST   = IDXW'(NUM_MGR - 1);
  localparam logic            PICK_MODE = (MODE == ARB_MODE_FIXED);

  arb_state_t         state, state_nxt;
  logic [NUM_MGR-1:0] grant_q, grant_nxt;
  logic [IDXW-1:0]    idx_q, idx_nxt;
  logic [IDXW-1:0]    rr_ptr, ptr_nxt;
  logic [HCW-1:0]     hold_cnt, hold_nxt;

  logic [NUM_MGR-1:0] cand_req;
  logic [NUM_MGR-1:0] win_onehot;
  logic [IDXW-1:0]    win_idx;
  logic               win_any;
  logic               owner_req;
  logic               owner_lock;
  logic               win_lock;

  // The current owner is always excluded from the candidates. That is exactly
  // the forced-handover set, and harmless elsewhere: in IDLE grant is zero,
  // and re-arbitration only happens once the owner has dropped its request.
  // rr_ptr always equals the owner index, so one selector serves every case.
  assign cand_req   = req & ~grant_q;
  assign owner_req  = |(req & grant_q);
  assign owner_lock = |(lock & grant_q);
  assign win_lock   = |(lock & win_onehot);

  arb_pick #(
    .NUM_MGR (NUM_MGR),
    .IDXW    (IDXW)
  ) u_pick (
    .req_vec    (cand_req),
    .ptr        (rr_ptr),
    .mode       (PICK_MODE),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr   <= PTR_RST;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      idx_q    <= idx_nxt;
      rr_ptr   <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    logic                   take_win;
    logic                   release_bus;
    logic [ARB_MAX_MGR-1:0] grant_wide;
    state_nxt   = state;
    grant_nxt   = grant_q;
    ptr_nxt     = rr_ptr;
    hold_nxt    = hold_cnt;
    take_win    = 1'b0;
    release_bus = 1'b0;
    grant_wide  = '0;

    if (HREADY) begin
      unique case (state)
        IDLE: begin
          take_win = win_any;
        end
        OWNED: begin
          if (owner_lock) begin
            // Lock wins over a simultaneous request drop.
            state_nxt = LOCKED;
            hold_nxt  = '0;
          end else if (!owner_req) begin
            take_win    = win_any;
            release_bus = !win_any;
          end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && win_any) begin
            take_win = 1'b1;
          end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) begin
            hold_nxt = hold_cnt + HCW'(1);
          end
        end
        LOCKED: begin
          hold_nxt = '0;
          if (!owner_lock) begin
            if (owner_req) begin
              state_nxt = OWNED;
            end else begin
              take_win    = win_any;
              release_bus = !win_any;
            end
          end
        end
        default: begin
          release_bus = 1'b1;
        end
      endcase

      if (take_win) begin
        grant_nxt = win_onehot;
        ptr_nxt   = win_idx;
        hold_nxt  = '0;
        state_nxt = win_lock ? LOCKED : OWNED;
      end
      if (release_bus) begin
        grant_nxt = '0;
        hold_nxt  = '0;
        state_nxt = IDLE;
      end
    end

    grant_wide[NUM_MGR-1:0] = grant_nxt;
    idx_nxt = IDXW'(onehot_to_idx(grant_wide));
  end

  // Outputs.
  always_comb begin
    grant        = grant_q;
    grant_idx    = idx_q;
    grant_valid  = |grant_q;
    grant_locked = (state == LOCKED);
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter. Two instances share the stimulus: a round-robin
// arbiter with a hold limit of 3 and a fixed-priority arbiter with no limit.
// Each is compared every cycle against a behavioural model built from the
// arbitration rules, plus directed expectations at key points.
module tb_ahb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic       hready = 1'b1;

  logic [3:0] g0, g1;
  logic [1:0] gi0, gi1;
  logic       gv0, gv1, gl0, gl1;

  int checks = 0;
  int passed = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  int m_owner  [2];
  int m_ptr    [2];
  int m_beats  [2];
  bit m_locked [2];
  int m_mode   [2] = '{0, 1};
  int m_maxh   [2] = '{3, 0};

  always #5 clk = ~clk;

  ahb_rr_arbiter #(.NUM_MGR(4), .MODE(0), .MAX_HOLD(3)) dut_rr (
    .clk(clk), .reset(rst), .req(req), .lock(lock), .HREADY(hready),
    .grant(g0), .grant_idx(gi0), .grant_valid(gv0), .grant_locked(gl0)
  );

  ahb_rr_arbiter #(.NUM_MGR(4), .MODE(1), .MAX_HOLD(0)) dut_fp (
    .clk(clk), .reset(rst), .req(req), .lock(lock), .HREADY(hready),
    .grant(g1), .grant_idx(gi1), .grant_valid(gv1), .grant_locked(gl1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [3:0] r, input int p, input int mode);
    if (mode == 1) begin
      for (int i = 0; i < 4; i++) if (r[i]) return i;
      return -1;
    end
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_owner[d]  = -1;
    m_ptr[d]    = 3;
    m_beats[d]  = 0;
    m_locked[d] = 1'b0;
  endtask

  task automatic model_take(input int d, input int w);
    if (w < 0) begin
      m_owner[d]  = -1;
      m_locked[d] = 1'b0;
      m_beats[d]  = 0;
    end else begin
      m_owner[d]  = w;
      m_ptr[d]    = w;
      m_beats[d]  = 0;
      m_locked[d] = lock[w];
    end
  endtask

  task automatic model_step(input int d);
    int o;
    logic [3:0] others;
    o = m_owner[d];
    if (rst) begin
      model_reset(d);
    end else if (hready) begin
      if (o < 0) begin
        if (req != 0) model_take(d, pick(req, m_ptr[d], m_mode[d]));
      end else if (!m_locked[d]) begin
        others = req;
        others[o] = 1'b0;
        if (lock[o]) begin
          m_locked[d] = 1'b1;
          m_beats[d]  = 0;
        end else if (!req[o]) begin
          model_take(d, pick(req, m_ptr[d], m_mode[d]));
        end else if (m_maxh[d] != 0 && m_beats[d] == m_maxh[d] - 1 && others != 0) begin
          model_take(d, pick(others, o, m_mode[d]));
        end else if (m_maxh[d] != 0 && m_beats[d] < m_maxh[d] - 1) begin
          m_beats[d]++;
        end
      end else begin
        m_beats[d] = 0;
        if (!lock[o]) begin
          if (req[o]) m_locked[d] = 1'b0;
          else        model_take(d, pick(req, m_ptr[d], m_mode[d]));
        end
      end
    end
  endtask

  task automatic check_dut(input int d);
    logic [3:0] eg;
    logic [1:0] ei;
    eg = (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
    ei = (m_owner[d] < 0) ? 2'd0 : 2'(m_owner[d]);
    if (d == 0) begin
      chk("rr_grant", 32'(g0), 32'(eg));
      chk("rr_idx", 32'(gi0), 32'(ei));
      chk("rr_valid", 32'(gv0), 32'(eg != 0));
      chk("rr_locked", 32'(gl0), 32'(m_locked[d]));
    end else begin
      chk("fp_grant", 32'(g1), 32'(eg));
      chk("fp_idx", 32'(gi1), 32'(ei));
      chk("fp_valid", 32'(gv1), 32'(eg != 0));
      chk("fp_locked", 32'(gl1), 32'(m_locked[d]));
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic h);
    req    = r;
    lock   = l;
    hready = h;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    logic [3:0] r, l;
    logic       h;
    model_reset(0);
    model_reset(1);

    // Reset state.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    chk("reset_grant", 32'(g0), 32'h0);
    rst = 1'b0;

    // Round-robin fairness: each owner drops its request after one beat.
    step(4'b1111, 4'b0000, 1'b1);
    chk("rr_first", 32'(g0), 32'h1);
    step(4'b1110, 4'b0000, 1'b1);
    chk("rr_to1", 32'(g0), 32'h2);
    step(4'b1101, 4'b0000, 1'b1);
    chk("rr_to2", 32'(g0), 32'h4);
    step(4'b1011, 4'b0000, 1'b1);
    chk("rr_to3", 32'(g0), 32'h8);
    step(4'b0111, 4'b0000, 1'b1);
    chk("rr_wrap0", 32'(g0), 32'h1);

    // Hold limit of 3 beats with managers 0 and 1 requesting.
    repeat (2) step(4'b0011, 4'b0000, 1'b1);
    chk("hold_keep0", 32'(g0), 32'h1);
    step(4'b0011, 4'b0000, 1'b1);
    chk("hold_to1", 32'(g0), 32'h2);
    repeat (3) step(4'b0011, 4'b0000, 1'b1);
    chk("hold_back0", 32'(g0), 32'h1);

    // Locked sequence by manager 2 is never preempted.
    step(4'b0100, 4'b0000, 1'b1);
    chk("lock_own2", 32'(g0), 32'h4);
    step(4'b1111, 4'b0100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 4'b0100, 1'b1);
      chk("lock_hold", 32'(g0), 32'h4);
      chk("lock_flag", 32'(gl0), 32'h1);
    end
    step(4'b1011, 4'b0000, 1'b1);
    chk("lock_release_grant", 32'(g0), 32'h8);
    chk("lock_release_idx", 32'(gi0), 32'h3);

    // HREADY stall freezes the grant.
    step(4'b0010, 4'b0000, 1'b1);
    chk("stall_own1", 32'(g0), 32'h2);
    for (int i = 0; i < 4; i++) begin
      step(4'b1001, 4'b0000, 1'b0);
      chk("stall_frozen", 32'(g0), 32'h2);
    end
    step(4'b1001, 4'b0000, 1'b1);
    chk("stall_handover", 32'(g0), 32'h8);

    // Fixed priority versus round-robin on the same requests.
    repeat (2) step(4'b1000, 4'b0000, 1'b1);
    chk("fp_own3", 32'(g1), 32'h8);
    step(4'b0010, 4'b0000, 1'b1);
    chk("fp_to1", 32'(g1), 32'h2);
    chk("rr_to1b", 32'(g0), 32'h2);
    step(4'b0101, 4'b0000, 1'b1);
    chk("fp_lowest", 32'(g1), 32'h1);
    chk("rr_next", 32'(g0), 32'h4);
    step(4'b0100, 4'b0000, 1'b1);
    chk("pre_reset_grant", 32'(g0), 32'h4);

    // Asynchronous reset mid-ownership.
    #2 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    chk("areset_grant", 32'(g0), 32'h0);
    chk("areset_valid", 32'(gv0), 32'h0);
    chk("areset_grant_fp", 32'(g1), 32'h0);
    step(4'b1111, 4'b0000, 1'b1);
    rst = 1'b0;
    step(4'b1111, 4'b0000, 1'b1);
    chk("post_reset_rr", 32'(g0), 32'h1);
    chk("post_reset_fp", 32'(g1), 32'h1);

    // Randomised phase against the model.
    r = 4'b0000;
    l = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        l = ($urandom_range(0, 1) == 0) ? (r & 4'($urandom_range(0, 15))) : 4'b0000;
      h = ($urandom_range(0, 3) != 0);
      step(r, l, h);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
